clock_enable_sequencer: RTL and testbench
=========================================

Name: clock_enable_sequencer

Overview:
Upstream configuration stage for the clock distributor. It owns cfg_enable, the per-output clock-enable mask, the divider ratios and the source selects, and applies them to the distributor in a glitch-safe order:
- After reset it holds the distributor off until PLL lock.
- It accepts one per-output reconfiguration request at a time.
- Each change follows a gate-off -> drain -> apply -> settle -> re-enable sequence, so a divider or source changes only while its output is held disabled.

Parameters:
NUM_CLOCK_OUTPUTS, 8, number of distributor outputs managed (1..8).
SETTLE_CYCLES, 16, ref_clk cycles waited in DRAIN and in SETTLE (>=1).
LOCK_TIMEOUT, 1024, cycles in BOOT before lock-timeout error is flagged (>=1).

Ports:
ref_clk  input  1  sequencer clock (same clock as distributor dividers).
rst_n  input  1  asynchronous active-low reset.
pll_locked  input  1  PLL lock indicator, synchronous to ref_clk.
req_valid  input  1  reconfiguration request valid.
req_ready  output  1  request accepted on the cycle where req_valid && req_ready.
req_out_idx  input  3  target output index.
req_div_ratio  input  4  new divider ratio (0 = pass-through).
req_src_sel  input  2  new source select.
req_enable  input  1  final enable state of the target output.
err_clear  input  1  clears seq_error / err_code.
cfg_enable  output  1  global distributor enable.
cfg_clk_enable  output  8  per-output enable mask.
cfg_div_ratio_flat  output  32  ratio for output i at bits [4i+3:4i].
cfg_source_sel_flat  output  16  source select for output i at bits [2i+1:2i].
seq_busy  output  1  high in every state other than BOOT and RUN.
seq_state  output  3  encoded state (BOOT=0, RUN=1, GATE_OFF=2, DRAIN=3, APPLY=4, SETTLE=5).
seq_error  output  1  sticky error.
err_code  output  8  last error code: 0x01 lock timeout, 0x02 bad index, 0x03 lock lost.

Behaviour:
- Reset values: all outputs 0, state BOOT. req_ready is a combinational function of state (high only in RUN, low in reset).
- BOOT:
  - Counter increments each cycle while pll_locked=0.
  - When the counter reaches LOCK_TIMEOUT: set seq_error, err_code=0x01. The counter saturates and the state stays BOOT.
  - When pll_locked=1: cfg_enable<=1 next cycle, counter cleared, go to RUN.
- RUN: req_ready=1. On handshake the request fields are latched.
  - Index >= NUM_CLOCK_OUTPUTS: seq_error, err_code=0x02, no cfg change, stay RUN.
  - Valid index: go to GATE_OFF.
- GATE_OFF (1 cycle): clear cfg_clk_enable[idx], even if it is already 0.
- DRAIN: wait exactly SETTLE_CYCLES cycles, then go to APPLY.
- APPLY (1 cycle): write div and src fields for idx. All other fields are unchanged.
- SETTLE: wait SETTLE_CYCLES cycles. Then cfg_clk_enable[idx]<=req_enable and go to RUN.
- Per-request timing: from the handshake, the enable bit falls 1 cycle later, and RUN is re-entered 2*SETTLE_CYCLES+3 cycles later.
- Bits of cfg_clk_enable / cfg fields at or above NUM_CLOCK_OUTPUTS are held at 0.
- While seq_busy=1: req_ready=0, and req_valid is ignored without side effects.
- Error register:
  - seq_error/err_code are sticky; err_clear clears them next cycle.
  - A new error in the same cycle as err_clear wins.
  - Errors never block operation.
- Reset mid-sequence: all configuration returns to reset values immediately. A half-applied request is discarded.
- pll_locked is ignored outside BOOT unless the optional feature is compiled in.

Optional Feature:
Macro CLK_SEQ_LOCK_LOSS_EN.
- With it: pll_locked=0 in any non-BOOT state means:
  - Next cycle: cfg_enable<=0 and cfg_clk_enable<=0. The pre-loss mask is saved.
  - seq_error is set, err_code=0x03.
  - Any in-flight request is abandoned. Fields are written only if APPLY has already executed.
  - The state returns to BOOT.
  - On relock, BOOT exit restores cfg_enable=1 and the saved mask in the same cycle.
- Without it: lock loss is ignored after BOOT, and the 0x03 code is never produced.

Test Plan:
- Reset, pll_locked=0 for 1100 cycles -> seq_error=1, err_code=0x01 at cycle 1024, cfg_enable=0. Then pll_locked=1 -> cfg_enable=1 next cycle, state RUN.
- In RUN, request idx=2, div=4, src=1, enable=1 -> cfg_clk_enable[2] falls at +1. cfg_div_ratio_flat[11:8]=4 and src[5:4]=1 land only after 16 DRAIN cycles. Bit 2 rises, and RUN is re-entered, at +35.
- Request idx=5 with req_valid held high during busy -> only the first handshake is taken, and no second sequence runs.
- Request idx=7 with NUM_CLOCK_OUTPUTS=4 -> err_code=0x02, all cfg outputs unchanged. err_clear together with another bad request -> error still set.
- rst_n asserted during DRAIN -> all outputs 0 at once, state BOOT after release.
- With CLK_SEQ_LOCK_LOSS_EN and mask 0x0F:
  - Drop pll_locked -> cfg_enable and mask go to 0, err_code=0x03.
  - Relock -> mask 0x0F restored.
  - Without the macro, the same stimulus leaves outputs unchanged.

Source files
------------

// File: rtl/clock_enable_sequencer.sv
// Glitch-safe configuration sequencer for the clock distributor (gate-off, drain, apply, settle, re-enable).
// Optional lock-loss handling is compiled in with `define CLK_SEQ_LOCK_LOSS_EN.
module clock_enable_sequencer #(
   parameter int NUM_CLOCK_OUTPUTS = 8,
   parameter int SETTLE_CYCLES     = 16,
   parameter int LOCK_TIMEOUT      = 1024
) (
   input  logic        ref_clk,
   input  logic        rst_n,
   input  logic        pll_locked,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_out_idx,
   input  logic [3:0]  req_div_ratio,
   input  logic [1:0]  req_src_sel,
   input  logic        req_enable,
   input  logic        err_clear,
   output logic        cfg_enable,
   output logic [7:0]  cfg_clk_enable,
   output logic [31:0] cfg_div_ratio_flat,
   output logic [15:0] cfg_source_sel_flat,
   output logic        seq_busy,
   output logic [2:0]  seq_state,
   output logic        seq_error,
   output logic [7:0]  err_code
);

   typedef enum logic [2:0] {
      BOOT     = 3'd0,
      RUN      = 3'd1,
      GATE_OFF = 3'd2,
      DRAIN    = 3'd3,
      APPLY    = 3'd4,
      SETTLE   = 3'd5
   } state_t;

   localparam int CNT_MAX = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] TIMEOUT_C   = CW'(LOCK_TIMEOUT);
   localparam logic [CW-1:0] TIMEOUT_M1  = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [7:0]    VALID_MASK  = 8'((1 << NUM_CLOCK_OUTPUTS) - 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      idx_q;
   logic [3:0]      div_q;
   logic [1:0]      src_q;
   logic            en_q;
   logic            handshake;
   logic            bad_idx;
   logic            timeout_hit;
   logic            lock_loss;
   logic [7:0]      boot_mask;

   assign req_ready   = (state == RUN);
   assign seq_busy    = (state != BOOT) && (state != RUN);
   assign seq_state   = state;
   assign handshake   = req_valid && req_ready;
   assign bad_idx     = handshake && (int'(req_out_idx) >= NUM_CLOCK_OUTPUTS);
   assign timeout_hit = (state == BOOT) && !pll_locked && (cnt == TIMEOUT_M1);

`ifdef CLK_SEQ_LOCK_LOSS_EN
   logic [7:0] saved_mask;
   assign lock_loss = (state != BOOT) && !pll_locked;
   assign boot_mask = saved_mask;

   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n)
         saved_mask <= '0;
      else if (lock_loss)
         saved_mask <= cfg_clk_enable;
   end
`else
   assign lock_loss = 1'b0;
   assign boot_mask = '0;
`endif

   // Outputs are written on the edge that enters a state, so each state's
   // effect (bit cleared, fields applied, bit restored) is visible while in it.
   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= BOOT;
         cnt                 <= '0;
         idx_q               <= '0;
         div_q               <= '0;
         src_q               <= '0;
         en_q                <= 1'b0;
         cfg_enable          <= 1'b0;
         cfg_clk_enable      <= '0;
         cfg_div_ratio_flat  <= '0;
         cfg_source_sel_flat <= '0;
      end else if (lock_loss) begin
         cfg_enable     <= 1'b0;
         cfg_clk_enable <= '0;
         cnt            <= '0;
         state          <= BOOT;
      end else begin
         case (state)
            BOOT: begin
               if (pll_locked) begin
                  cfg_enable     <= 1'b1;
                  cfg_clk_enable <= boot_mask & VALID_MASK;
                  cnt            <= '0;
                  state          <= RUN;
               end else if (cnt != TIMEOUT_C) begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               if (handshake && !bad_idx) begin
                  idx_q                       <= req_out_idx;
                  div_q                       <= req_div_ratio;
                  src_q                       <= req_src_sel;
                  en_q                        <= req_enable;
                  cfg_clk_enable[req_out_idx] <= 1'b0;
                  state                       <= GATE_OFF;
               end
            end
            GATE_OFF: begin
               cnt   <= '0;
               state <= DRAIN;
            end
            DRAIN: begin
               if (cnt == SETTLE_LAST) begin
                  cnt                              <= '0;
                  cfg_div_ratio_flat[4*idx_q +: 4] <= div_q;
                  cfg_source_sel_flat[2*idx_q +: 2] <= src_q;
                  state                            <= APPLY;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            APPLY: begin
               cnt   <= '0;
               state <= SETTLE;
            end
            SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  cnt                   <= '0;
                  cfg_clk_enable[idx_q] <= en_q;
                  state                 <= RUN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

   // A fresh error in the same cycle as err_clear takes precedence.
   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_error <= 1'b0;
         err_code  <= '0;
      end else if (timeout_hit) begin
         seq_error <= 1'b1;
         err_code  <= 8'h01;
      end else if (lock_loss) begin
         seq_error <= 1'b1;
         err_code  <= 8'h03;
      end else if (bad_idx) begin
         seq_error <= 1'b1;
         err_code  <= 8'h02;
      end else if (err_clear) begin
         seq_error <= 1'b0;
         err_code  <= '0;
      end
   end

endmodule

// File: tb/tb_clock_enable_sequencer.sv
// Self-checking bench for clock_enable_sequencer: directed steps plus random requests against a
// behavioural model of the configuration registers and per-request timeline.
module tb_clock_enable_sequencer;

   localparam int NUM = 4;
   localparam int S   = 16;
   localparam int LT  = 1024;

   logic        ref_clk;
   logic        rst_n;
   logic        pll_locked;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_out_idx;
   logic [3:0]  req_div_ratio;
   logic [1:0]  req_src_sel;
   logic        req_enable;
   logic        err_clear;
   logic        cfg_enable;
   logic [7:0]  cfg_clk_enable;
   logic [31:0] cfg_div_ratio_flat;
   logic [15:0] cfg_source_sel_flat;
   logic        seq_busy;
   logic [2:0]  seq_state;
   logic        seq_error;
   logic [7:0]  err_code;

   clock_enable_sequencer #(
      .NUM_CLOCK_OUTPUTS (NUM),
      .SETTLE_CYCLES     (S),
      .LOCK_TIMEOUT      (LT)
   ) dut (
      .ref_clk             (ref_clk),
      .rst_n               (rst_n),
      .pll_locked          (pll_locked),
      .req_valid           (req_valid),
      .req_ready           (req_ready),
      .req_out_idx         (req_out_idx),
      .req_div_ratio       (req_div_ratio),
      .req_src_sel         (req_src_sel),
      .req_enable          (req_enable),
      .err_clear           (err_clear),
      .cfg_enable          (cfg_enable),
      .cfg_clk_enable      (cfg_clk_enable),
      .cfg_div_ratio_flat  (cfg_div_ratio_flat),
      .cfg_source_sel_flat (cfg_source_sel_flat),
      .seq_busy            (seq_busy),
      .seq_state           (seq_state),
      .seq_error           (seq_error),
      .err_code            (err_code)
   );

   int total = 0;
   int bad   = 0;

   // Behavioural model of the distributor configuration
   logic [3:0] exp_div [8];
   logic [1:0] exp_src [8];
   logic [7:0] exp_mask;
   logic       exp_en;
   logic       exp_err;
   logic [7:0] exp_code;
   logic [7:0] saved;

   initial ref_clk = 1'b0;
   always #5 ref_clk = ~ref_clk;

   function automatic logic [31:0] div_flat();
      logic [31:0] r = '0;
      for (int i = 0; i < 8; i++) r[4*i +: 4] = exp_div[i];
      return r;
   endfunction

   function automatic logic [15:0] src_flat();
      logic [15:0] r = '0;
      for (int i = 0; i < 8; i++) r[2*i +: 2] = exp_src[i];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         exp_div[i] = '0;
         exp_src[i] = '0;
      end
      exp_mask = '0;
      exp_en   = 1'b0;
      exp_err  = 1'b0;
      exp_code = '0;
   endtask

   task automatic tick();
      @(posedge ref_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cfg(input string tag);
      chk({tag, ".cfg_enable"}, 32'(cfg_enable), 32'(exp_en));
      chk({tag, ".mask"}, 32'(cfg_clk_enable), 32'(exp_mask));
      chk({tag, ".div"}, cfg_div_ratio_flat, div_flat());
      chk({tag, ".src"}, 32'(cfg_source_sel_flat), 32'(src_flat()));
      chk({tag, ".err"}, 32'(seq_error), 32'(exp_err));
      chk({tag, ".code"}, 32'(err_code), 32'(exp_code));
   endtask

   // Expected per-cycle state after the handshake: GATE_OFF at +1, S DRAIN cycles,
   // one APPLY, S SETTLE cycles, RUN at +2S+3.
   function automatic logic [2:0] exp_state_at(input int c);
      if (c == 1) return 3'd2;
      if (c <= S + 1) return 3'd3;
      if (c == S + 2) return 3'd4;
      if (c <= 2*S + 2) return 3'd5;
      return 3'd1;
   endfunction

   task automatic do_req(input int idx, input logic [3:0] d, input logic [1:0] s,
                         input logic en, input bit hold, input bit clr);
      req_valid     = 1'b1;
      req_out_idx   = 3'(idx);
      req_div_ratio = d;
      req_src_sel   = s;
      req_enable    = en;
      err_clear     = clr;
      tick();
      err_clear = 1'b0;
      if (!hold) req_valid = 1'b0;
      if (idx >= NUM) begin
         exp_err  = 1'b1;
         exp_code = 8'h02;
         chk("bad.state", 32'(seq_state), 32'd1);
         chk_cfg("bad");
         return;
      end
      if (clr) begin
         exp_err  = 1'b0;
         exp_code = '0;
      end
      exp_mask[idx] = 1'b0;
      chk("req.state1", 32'(seq_state), 32'd2);
      chk("req.mask1", 32'(cfg_clk_enable), 32'(exp_mask));
      chk("req.ready1", 32'(req_ready), 32'd0);
      for (int c = 2; c <= 2*S + 3; c++) begin
         if (hold && c < 2*S + 2) begin
            req_out_idx   = 3'($urandom_range(0, 7));
            req_div_ratio = 4'($urandom_range(0, 15));
            req_src_sel   = 2'($urandom_range(0, 3));
            req_enable    = 1'($urandom_range(0, 1));
         end
         if (c == 2*S + 3) req_valid = 1'b0;
         tick();
         if (c == S + 3) begin
            exp_div[idx] = d;
            exp_src[idx] = s;
         end
         if (c == 2*S + 3) exp_mask[idx] = en;
         chk($sformatf("req.state+%0d", c), 32'(seq_state), 32'(exp_state_at(c)));
         chk($sformatf("req.mask+%0d", c), 32'(cfg_clk_enable), 32'(exp_mask));
         chk($sformatf("req.busy+%0d", c), 32'(seq_busy), 32'(c <= 2*S + 2));
         if (c != S + 2) begin
            chk($sformatf("req.div+%0d", c), cfg_div_ratio_flat, div_flat());
            chk($sformatf("req.src+%0d", c), 32'(cfg_source_sel_flat), 32'(src_flat()));
         end
      end
      chk_cfg("req.end");
      if (hold) begin
         repeat (3) tick();
         chk("hold.state", 32'(seq_state), 32'd1);
         chk_cfg("hold");
      end
   endtask

   initial begin
      rst_n = 1'b0; pll_locked = 1'b0; req_valid = 1'b0; req_out_idx = '0;
      req_div_ratio = '0; req_src_sel = '0; req_enable = 1'b0; err_clear = 1'b0;
      model_reset();
      saved = '0;
      repeat (3) tick();
      chk("rst.state", 32'(seq_state), 32'd0);
      chk("rst.ready", 32'(req_ready), 32'd0);
      chk("rst.busy", 32'(seq_busy), 32'd0);
      chk_cfg("rst");

      // Lock timeout
      rst_n = 1'b1;
      repeat (LT - 1) tick();
      chk("boot.err_early", 32'(seq_error), 32'd0);
      tick();
      exp_err = 1'b1; exp_code = 8'h01;
      chk_cfg("boot.timeout");
      repeat (1100 - LT) tick();
      chk("boot.state", 32'(seq_state), 32'd0);
      chk_cfg("boot.sat");

      pll_locked = 1'b1;
      tick();
      exp_en = 1'b1;
      chk("lock.state", 32'(seq_state), 32'd1);
      chk("lock.ready", 32'(req_ready), 32'd1);
      chk_cfg("lock");
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      exp_err = 1'b0; exp_code = '0;
      chk_cfg("clr");

      // Directed requests
      do_req(2, 4'd4, 2'd1, 1'b1, 1'b0, 1'b0);
      chk("dir.div2", 32'(cfg_div_ratio_flat[11:8]), 32'd4);
      do_req(3, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b0);
      do_req(7, 4'd9, 2'd2, 1'b1, 1'b0, 1'b0);
      do_req(6, 4'd3, 2'd3, 1'b0, 1'b0, 1'b1);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      exp_err = 1'b0; exp_code = '0;
      chk_cfg("clr2");

      // Random requests
      repeat (6) begin
         do_req(int'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < NUM; i++)
         do_req(i, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b1);
      chk("mask.full", 32'(cfg_clk_enable), 32'h0F);

      // Lock loss while running
      pll_locked = 1'b0;
      tick();
`ifdef CLK_SEQ_LOCK_LOSS_EN
      saved = exp_mask; exp_mask = '0; exp_en = 1'b0; exp_err = 1'b1; exp_code = 8'h03;
      chk("loss.state", 32'(seq_state), 32'd0);
`else
      chk("loss.state", 32'(seq_state), 32'd1);
`endif
      chk_cfg("loss");
      tick();
      chk_cfg("loss2");
      pll_locked = 1'b1;
      tick();
`ifdef CLK_SEQ_LOCK_LOSS_EN
      exp_mask = saved; exp_en = 1'b1;
`endif
      chk("relock.state", 32'(seq_state), 32'd1);
      chk_cfg("relock");

      // Reset during DRAIN
      req_valid = 1'b1; req_out_idx = 3'd1; req_div_ratio = 4'd7; req_src_sel = 2'd2; req_enable = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (4) tick();
      chk("drain.state", 32'(seq_state), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst.state", 32'(seq_state), 32'd0);
      chk("arst.ready", 32'(req_ready), 32'd0);
      chk_cfg("arst");
      tick();
      rst_n = 1'b1;
      chk("rel.state", 32'(seq_state), 32'd0);
      tick();
      exp_en = 1'b1;
      chk("rel.run", 32'(seq_state), 32'd1);
      chk_cfg("rel");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
